// File: rtl/cdc_fifo_write_arbiter.sv
// Round-robin arbiter sharing one cdc_fifo write port; grants last for a burst (last / max_burst / valid gap).
// Latency: first word of a grant is written one cycle after IDLE sees it; wr_ready low stalls the burst in place.
module cdc_fifo_write_arbiter #(
  parameter int num_requesters = 4,
  parameter int data_width     = 32,
  parameter int max_burst      = 8
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [num_requesters*data_width-1:0] req_data,
  input  logic [num_requesters-1:0]            req_valid,
  input  logic [num_requesters-1:0]            req_last,
  output logic [num_requesters-1:0]            req_ready,
  output logic [data_width-1:0]                wr_data,
  output logic                                 wr,
  input  logic                                 wr_ready,
  output logic [$clog2(num_requesters)-1:0]    grant_idx,
  output logic                                 busy
);

  localparam int IDXW = $clog2(num_requesters);
  localparam int BCW  = $clog2(max_burst + 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] grant_q, grant_d;
  logic [IDXW-1:0] rr_last_q, rr_last_d;
  logic [BCW-1:0]  beat_q, beat_d;

  logic g_vld;
  logic xfer;

  assign g_vld = req_valid[grant_q];
  assign xfer  = (state_q == BURST) & g_vld & wr_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_last_q <= IDXW'(num_requesters - 1);
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
      beat_q    <= beat_d;
    end
  end

  always_comb begin
    logic            found;
    logic [IDXW-1:0] pick;
    int              idx;
    state_d   = state_q;
    grant_d   = grant_q;
    rr_last_d = rr_last_q;
    beat_d    = beat_q;
    found     = 1'b0;
    pick      = '0;
    idx       = 0;
    // Search starts just after the last served requester so everyone gets a turn.
    for (int off = 1; off <= num_requesters; off++) begin
      idx = (int'(rr_last_q) + off) % num_requesters;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = IDXW'(idx);
      end
    end
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          beat_d  = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (!g_vld || (xfer && (req_last[grant_q] || beat_q == BCW'(max_burst - 1)))) begin
          state_d   = IDLE;
          rr_last_d = grant_q;
        end else begin
          beat_d = beat_q + BCW'(xfer);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are gated by reset_n so a mid-burst reset writes nothing in its own cycle.
  always_comb begin
    wr        = 1'b0;
    req_ready = '0;
    busy      = 1'b0;
    wr_data   = req_data[grant_q*data_width +: data_width];
    grant_idx = grant_q;
    if (reset_n && state_q == BURST) begin
      wr                 = g_vld;
      req_ready[grant_q] = xfer;
      busy               = 1'b1;
    end
  end

endmodule

// File: tb/tb_cdc_fifo_write_arbiter.sv
// Directed bench for cdc_fifo_write_arbiter: producers are modelled by word counters,
// expected FIFO writes are queued by the stimulus and consumed by a negedge monitor.
module tb_cdc_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 8;

  logic              clk;
  logic              reset_n;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_last;
  logic [N-1:0]      req_ready;
  logic [DW-1:0]     wr_data;
  logic              wr;
  logic              wr_ready;
  logic [1:0]        grant_idx;
  logic              busy;

  cdc_fifo_write_arbiter #(
    .num_requesters(N),
    .data_width    (DW),
    .max_burst     (MB)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_data (req_data),
    .req_valid(req_valid),
    .req_last (req_last),
    .req_ready(req_ready),
    .wr_data  (wr_data),
    .wr       (wr),
    .wr_ready (wr_ready),
    .grant_idx(grant_idx),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            gap;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   last_wr_cyc = 0;
  int   wr_cnt   = 0;
  int   rdy_cnt  = 0;
  int   pushed   = 0;

  // Producer model: cnt = words left, seq = next sequence number, lastp: 0 never, 1 every word, 2 final word.
  int cnt[N];
  int seq[N];
  int lastp[N];
  int exp_seq[N];

  task automatic check(input string name, input longint act, input longint expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  function automatic logic [DW-1:0] word(input int r, input int s);
    return {8'(r), 24'(s)};
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = (cnt[i] > 0);
      req_data[i*DW +: DW]    = word(i, seq[i]);
      req_last[i]             = (cnt[i] > 0) && ((lastp[i] == 1) || (lastp[i] == 2 && cnt[i] == 1));
    end
  endtask

  task automatic run_cycles(input int n);
    logic [N-1:0] acc;
    repeat (n) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          seq[i]++;
          cnt[i]--;
        end
      end
      drive();
    end
  endtask

  // Queue n expected words from requester r; first one gap cycles after the previous write (-1: any).
  task automatic exp_push(input int r, input int n, input int first_gap);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.data = word(r, exp_seq[r]);
      e.gap  = (k == 0) ? first_gap : 1;
      exp_seq[r]++;
      exp_q.push_back(e);
      pushed++;
    end
  endtask

  task automatic set_src(input int r, input int n, input int lp);
    cnt[r]   = n;
    lastp[r] = lp;
    drive();
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    rdy_cnt += $countones(req_ready);
    if (wr && wr_ready) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", longint'(wr_data), 0);
      end else begin
        e = exp_q.pop_front();
        check("wr_data", longint'(wr_data), longint'(e.data));
        if (e.gap >= 0) check("write_gap", cyc - last_wr_cyc, e.gap);
      end
      last_wr_cyc = cyc;
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0; seq[i] = 0; lastp[i] = 0; exp_seq[i] = 0;
    end
    reset_n  = 1'b0;
    wr_ready = 1'b1;
    req_data = '0;
    req_valid = '0;
    req_last = '0;

    // Reset held with every requester valid
    set_src(0, 2, 1);
    set_src(1, 1, 2);
    set_src(2, 1, 2);
    set_src(3, 1, 2);
    repeat (3) @(posedge clk);
    #1;
    check("reset_wr", wr, 0);
    check("reset_req_ready", req_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_grant_idx", grant_idx, 0);

    // Round-robin, one word per grant
    exp_push(0, 1, -1);
    exp_push(1, 1, 2);
    exp_push(2, 1, 2);
    exp_push(3, 1, 2);
    exp_push(0, 1, 2);
    reset_n = 1'b1;
    run_cycles(25);

    // Max burst: req1 wins first (rr_last=0), both cut at 8 words
    set_src(0, 20, 0);
    set_src(1, 10, 0);
    exp_push(1, 8, -1);
    exp_push(0, 8, 2);
    exp_push(1, 2, 2);
    exp_push(0, 8, 3);
    exp_push(0, 4, 2);
    run_cycles(70);

    // Backpressure: 5 stalled cycles after 3 words, burst still ends at 8 words
    set_src(3, 12, 0);
    exp_push(3, 3, -1);
    exp_push(3, 5, 6);
    exp_push(3, 4, 2);
    run_cycles(4);
    wr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      run_cycles(1);
      check("stall_req_ready", req_ready, 0);
      check("stall_grant", grant_idx, 3);
      check("stall_busy", busy, 1);
    end
    wr_ready = 1'b1;
    run_cycles(25);

    // Gap: req2 drops valid after 3 words, req3 then req1 follow
    set_src(2, 3, 0);
    exp_push(2, 3, -1);
    exp_push(3, 1, 3);
    exp_push(1, 1, 2);
    run_cycles(2);
    check("gap_grant", grant_idx, 2);
    set_src(1, 1, 2);
    set_src(3, 1, 2);
    run_cycles(20);

    // Reset after word 4 of req2's burst; req0 must be granted first afterwards
    set_src(2, 8, 0);
    set_src(0, 2, 2);
    exp_push(2, 4, -1);
    exp_push(0, 2, 4);
    exp_push(2, 4, 2);
    run_cycles(5);
    reset_n = 1'b0;
    #1;
    check("midrst_wr", wr, 0);
    check("midrst_req_ready", req_ready, 0);
    run_cycles(2);
    reset_n = 1'b1;
    run_cycles(1);
    check("post_reset_grant", grant_idx, 0);
    check("post_reset_busy", busy, 1);
    run_cycles(30);

    check("idle_busy_end", busy, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    check("write_count", wr_cnt, pushed);
    check("wr_vs_ready_pulses", wr_cnt, rdy_cnt);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
